sr_cmd_sequencer: RTL and testbench

SR_CMD_SEQUENCER -- requirements
Module: sr_cmd_sequencer

---
 rtl/sr_cmd_pkg.sv | 38 +++
 rtl/sr_cmd_fifo.sv | 72 +++++++
 rtl/sr_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg -- shared types and constants for the SR command sequencer.
//   op_e        : command opcodes (NOP, CLR, SET, TOGGLE)
//   state_e     : sequencer FSM states (IDLE, DRIVE, GAP)
//   FIFO_DEPTH  : depth of the optional command FIFO
//   CNT_W       : width of the hold/gap counter
//   resolve_set : turns an opcode plus the fed-back q into a set/clear decision
package sr_cmd_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_CLR    = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    // 1 = drive s, 0 = drive r. TOGGLE inverts the current flip-flop state.
    function automatic logic resolve_set(input op_e op, input logic q);
        logic set_v;
        case (op)
            OP_SET:    set_v = 1'b1;
            OP_CLR:    set_v = 1'b0;
            OP_TOGGLE: set_v = ~q;
            default:   set_v = 1'b0;
        endcase
        return set_v;
    endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// sr_cmd_fifo -- 4-entry x 2-bit command FIFO with registered full/empty.
// Only instantiated by sr_cmd_sequencer when SR_CMD_FIFO_EN is defined.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   push, push_op     : write request and opcode (ignored when full)
//   pop               : read request (ignored when empty)
//   head_op           : opcode at the read pointer
//   full, empty       : registered occupancy flags
module sr_cmd_fifo
    import sr_cmd_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  op_e  push_op,
    input  logic pop,
    output op_e  head_op,
    output logic full,
    output logic empty
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_next_s;
    op_e              mem_r [FIFO_DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head_op   = mem_r[rd_ptr_r];

    // Occupancy after this edge, used to register full/empty.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers (wrap naturally at 2 bits) and flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            full     <= 1'b0;
            empty    <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= OP_NOP;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_op;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full    <= (count_next_s == DEPTH_C);
            empty   <= (count_next_s == {(PTR_W+1){1'b0}});
        end
    end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer -- turns SET/CLR/TOGGLE/NOP commands into timed s/r
// pulses for a downstream SR flip-flop, with a hold phase and a gap phase.
// Optional macro SR_CMD_FIFO_EN adds a 4-entry command FIFO in front of the FSM.
// Parameters: HOLD_CYCLES (1..15) drive length, GAP_CYCLES (0..15) idle gap.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   cmd_valid, cmd_op   : command handshake input and opcode
//   cmd_ready           : command accepted when cmd_valid && cmd_ready at an edge
//   q_fb                : q fed back from the flip-flop (TOGGLE resolution)
//   s, r                : registered set / reset drives, never both high
//   busy                : FSM not idle or a command queued
//   done                : one-cycle pulse per completed command
module sr_cmd_sequencer
    import sr_cmd_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    input  logic       q_fb,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       done
);

    // Counter load values: the counter runs N-1 .. 0, so the phase lasts N cycles.
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1)
                                                            : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             idle_r;      // mirrors state_r==ST_IDLE but held 0 in reset
    logic             dispatch_s;
    op_e              disp_op_s;
    logic             queued_s;
    logic             set_s;

`ifdef SR_CMD_FIFO_EN
    logic run_r;
    logic push_s;
    logic pop_s;
    op_e  head_op_s;
    logic fifo_full_s;
    logic fifo_empty_s;

    // Holds cmd_ready low while in reset; FIFO full gates it otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // full is a register, so a pop cannot open a slot for a push in the same cycle.
    assign cmd_ready  = run_r && !fifo_full_s;
    assign push_s     = cmd_valid && cmd_ready;
    // empty is registered, so a push into an empty FIFO dispatches one edge later.
    assign pop_s      = idle_r && !fifo_empty_s;
    assign dispatch_s = pop_s;
    assign disp_op_s  = head_op_s;
    assign queued_s   = !fifo_empty_s;

    sr_cmd_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .push_op (op_e'(cmd_op)),
        .pop     (pop_s),
        .head_op (head_op_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );
`else
    assign cmd_ready  = idle_r;
    assign dispatch_s = cmd_valid && idle_r;
    assign disp_op_s  = op_e'(cmd_op);
    assign queued_s   = 1'b0;
`endif

    // TOGGLE is resolved against q_fb at the dispatch edge only.
    assign set_s = resolve_set(disp_op_s, q_fb);
    assign busy  = (state_r != ST_IDLE) || queued_s;

    // Sequencer FSM with hold/gap counter and registered s/r/done/idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            s       <= 1'b0;
            r       <= 1'b0;
            done    <= 1'b0;
            idle_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (dispatch_s && (disp_op_s == OP_NOP)) begin
                        done   <= 1'b1;
                        idle_r <= 1'b1;
                    end else if (dispatch_s) begin
                        state_r <= ST_DRIVE;
                        cnt_r   <= HOLD_LD;
                        s       <= set_s;
                        r       <= ~set_s;
                        idle_r  <= 1'b0;
                    end else begin
                        idle_r <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        s    <= 1'b0;
                        r    <= 1'b0;
                        done <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_r <= ST_IDLE;
                            idle_r  <= 1'b1;
                        end else begin
                            state_r <= ST_GAP;
                            cnt_r   <= GAP_LD;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        idle_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    s       <= 1'b0;
                    r       <= 1'b0;
                    idle_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb_sr_cmd_sequencer -- directed bench for sr_cmd_sequencer.
// u_g1: HOLD=2 GAP=1, u_g0: HOLD=2 GAP=0; with SR_CMD_FIFO_EN also u_fq: HOLD=6 GAP=1.
module tb_sr_cmd_sequencer;

    localparam logic [1:0] C_NOP = 2'b00;
    localparam logic [1:0] C_CLR = 2'b01;
    localparam logic [1:0] C_SET = 2'b10;
    localparam logic [1:0] C_TGL = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       q_fb;
    logic       v1, v0;
    logic [1:0] op1, op0;
    logic       rdy1, s1, r1, busy1, done1;
    logic       rdy0, s0, r0, busy0, done0;

    int checks = 0;
    int errors = 0;
    int sel    = 1;

    typedef struct {
        string tag;
        logic  s;
        logic  r;
        logic  done;
        logic  busy;
        logic  ready;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sr_cmd_sequencer #(.HOLD_CYCLES(2), .GAP_CYCLES(1)) u_g1 (
        .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_op(op1), .cmd_ready(rdy1),
        .q_fb(q_fb), .s(s1), .r(r1), .busy(busy1), .done(done1)
    );

    sr_cmd_sequencer #(.HOLD_CYCLES(2), .GAP_CYCLES(0)) u_g0 (
        .clk(clk), .reset(reset), .cmd_valid(v0), .cmd_op(op0), .cmd_ready(rdy0),
        .q_fb(q_fb), .s(s0), .r(r0), .busy(busy0), .done(done0)
    );

`ifdef SR_CMD_FIFO_EN
    logic       vf;
    logic [1:0] opf;
    logic       rdyf, sf, rf, busyf, donef;
    logic [1:0] fops [6];
    logic       expq[$];

    sr_cmd_sequencer #(.HOLD_CYCLES(6), .GAP_CYCLES(1)) u_fq (
        .clk(clk), .reset(reset), .cmd_valid(vf), .cmd_op(opf), .cmd_ready(rdyf),
        .q_fb(q_fb), .s(sf), .r(rf), .busy(busyf), .done(donef)
    );
`endif

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Push the expected next-cycle outputs, advance one edge, then pop and compare.
    task automatic step(input string tag, input logic es, input logic er,
                        input logic ed, input logic eb, input logic erdy);
        exp_t e;
        e.tag = tag; e.s = es; e.r = er; e.done = ed; e.busy = eb; e.ready = erdy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (sel == 1) begin
            chk({e.tag, ".s"},     s1,    e.s);
            chk({e.tag, ".r"},     r1,    e.r);
            chk({e.tag, ".done"},  done1, e.done);
            chk({e.tag, ".busy"},  busy1, e.busy);
            chk({e.tag, ".ready"}, rdy1,  e.ready);
            chk({e.tag, ".excl"},  s1 & r1, 1'b0);
        end else begin
            chk({e.tag, ".s"},     s0,    e.s);
            chk({e.tag, ".r"},     r0,    e.r);
            chk({e.tag, ".done"},  done0, e.done);
            chk({e.tag, ".busy"},  busy0, e.busy);
            chk({e.tag, ".ready"}, rdy0,  e.ready);
            chk({e.tag, ".excl"},  s0 & r0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0; q_fb = 1'b0;
        v1 = 1'b0; v0 = 1'b0; op1 = C_NOP; op0 = C_NOP;
`ifdef SR_CMD_FIFO_EN
        vf = 1'b0; opf = C_NOP;
        fops[0] = C_SET; fops[1] = C_CLR; fops[2] = C_SET;
        fops[3] = C_CLR; fops[4] = C_SET; fops[5] = C_CLR;
`endif
        #2;
        // Reset state and release.
        sel = 1; step("rst_g1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sel = 0; step("rst_g0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        sel = 1; step("release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifndef SR_CMD_FIFO_EN
        // SET with HOLD=2 GAP=1; cmd_valid kept high while busy must be ignored.
        v1 = 1'b1; op1 = C_SET;
        step("set_c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        op1 = C_CLR;
        step("set_c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("set_c3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        v1 = 1'b0;
        step("set_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("no_latch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // TOGGLE with q_fb=1 clears; q_fb change after dispatch has no effect.
        q_fb = 1'b1; v1 = 1'b1; op1 = C_TGL;
        step("tgl1_c1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        v1 = 1'b0; q_fb = 1'b0;
        step("tgl1_c2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("tgl1_c3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("tgl1_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // TOGGLE with q_fb=0 sets.
        v1 = 1'b1;
        step("tgl0_c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        v1 = 1'b0; q_fb = 1'b1;
        step("tgl0_c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("tgl0_c3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("tgl0_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        q_fb = 1'b0;

        // NOP completes immediately.
        v1 = 1'b1; op1 = C_NOP;
        step("nop_c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        v1 = 1'b0;
        step("nop_c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the second DRIVE cycle aborts without done.
        v1 = 1'b1; op1 = C_SET;
        step("abort_c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        v1 = 1'b0;
        step("abort_c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step("abort_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step("abort_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("abort_c5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // GAP=0: back-to-back CLR, second accepted in the done cycle.
        sel = 0; v0 = 1'b1; op0 = C_CLR;
        step("g0_c1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("g0_c2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("g0_c3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("g0_c4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        v0 = 1'b0;
        step("g0_c5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("g0_c6", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("g0_c7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        // FIFO: six commands offered back to back; the queue fills while the
        // first runs, so the sixth waits for the first pop, and all run in order.
        begin
            int   idx     = 0;
            int   holdoff = 0;
            int   got     = 0;
            logic prev    = 1'b0;
            for (int c = 0; c < 200 && got < 6; c++) begin
                if (idx < 6) begin
                    vf = 1'b1; opf = fops[idx];
                end else begin
                    vf = 1'b0;
                end
                if (vf && !rdyf) holdoff++;
                if (vf && rdyf) begin
                    expq.push_back(fops[idx] == C_SET);
                    idx++;
                end
                @(posedge clk);
                #1;
                chk("fifo_excl", sf & rf, 1'b0);
                if ((sf | rf) && !prev) begin
                    if (expq.size() > 0) begin
                        chk("fifo_order", sf, expq.pop_front());
                    end else begin
                        chk("fifo_unexpected_drive", 1'b1, 1'b0);
                    end
                    got++;
                end
                prev = sf | rf;
            end
            vf = 1'b0;
            chk("fifo_all_done", (got == 6), 1'b1);
            chk("fifo_holdoff5", (holdoff == 5), 1'b1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
